// File: rtl/cmem_arb_if.sv
// Port bundle for cmem_arb: two requester channels, the shared read-return path
// and the layer-memory strobe/address/data port.
interface cmem_arb_if #(
  parameter int AW = 12,
  parameter int DW = 20
);
  logic          r0_req;
  logic          r0_we;
  logic          r0_lock;
  logic [2:0]    r0_sel;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt;
  logic          r0_rvalid;

  logic          r1_req;
  logic          r1_we;
  logic          r1_lock;
  logic [2:0]    r1_sel;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt;
  logic          r1_rvalid;

  logic [DW-1:0] rdata;
  logic          cwr;
  logic          crd;
  logic [AW-1:0] caddr_wr;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_wr;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          err;

  // Arbiter side.
  modport slave (
    input  r0_req, r0_we, r0_lock, r0_sel, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_lock, r1_sel, r1_addr, r1_wdata,
    input  cdata_rd,
    output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata,
    output cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel, err
  );

  // Requesters plus memory, as seen from outside the arbiter.
  modport master (
    output r0_req, r0_we, r0_lock, r0_sel, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_lock, r1_sel, r1_addr, r1_wdata,
    output cdata_rd,
    input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata,
    input  cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel, err
  );
endinterface

// File: rtl/cmem_arb.sv
// Two-requester arbiter for the layer memories: round-robin with optional lock
// ownership, a one-cycle registered command stage and a registered read return.
module cmem_arb #(
  parameter int AW      = 12,
  parameter int DW      = 20,
  parameter int LOCK_TO = 16
) (
  input logic       clk,
  input logic       reset,
  cmem_arb_if.slave bus
);

  localparam int            CW      = $clog2(LOCK_TO + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TO - 1);

  logic          rr;
  logic          owner_valid;
  logic          owner_id;
  logic [CW-1:0] idle_cnt;
  logic          rd_id;

  logic          gnt0;
  logic          gnt1;
  logic          any_gnt;
  logic          win_id;
  logic          win_we;
  logic          win_lock;
  logic [2:0]    win_sel;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          win_legal;
  logic          owner_req;
  logic          timeout;

  // Grant decision: a valid owner excludes the other side, otherwise round-robin on contention.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (owner_valid) begin
        gnt0 = !owner_id && bus.r0_req;
        gnt1 = owner_id && bus.r1_req;
      end else if (bus.r0_req && bus.r1_req) begin
        gnt0 = !rr;
        gnt1 = rr;
      end else begin
        gnt0 = bus.r0_req;
        gnt1 = bus.r1_req;
      end
    end
  end

  assign bus.r0_gnt = gnt0;
  assign bus.r1_gnt = gnt1;
  assign any_gnt    = gnt0 | gnt1;
  assign win_id     = gnt1;

  assign win_we    = gnt1 ? bus.r1_we    : bus.r0_we;
  assign win_lock  = gnt1 ? bus.r1_lock  : bus.r0_lock;
  assign win_sel   = gnt1 ? bus.r1_sel   : bus.r0_sel;
  assign win_addr  = gnt1 ? bus.r1_addr  : bus.r0_addr;
  assign win_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;
  assign win_legal = (win_sel != 3'd0) && (win_sel < 3'd6);

  assign owner_req = owner_id ? bus.r1_req : bus.r0_req;
  assign timeout   = owner_valid && !owner_req && (idle_cnt == TO_LAST);

  // Ownership, round-robin pointer and the idle watchdog on a held lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr          <= 1'b0;
      owner_valid <= 1'b0;
      owner_id    <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      if (timeout) begin
        owner_valid <= 1'b0;
        rr          <= !owner_id;
        idle_cnt    <= '0;
      end else if (owner_valid && !owner_req) begin
        idle_cnt <= idle_cnt + CW'(1);
      end else begin
        idle_cnt <= '0;
      end

      if (any_gnt) begin
        if (win_lock) begin
          owner_valid <= 1'b1;
          owner_id    <= win_id;
        end else begin
          owner_valid <= 1'b0;
          rr          <= !win_id;
        end
      end
    end
  end

  // Command stage: an accepted request drives the memory port for exactly the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cwr      <= 1'b0;
      bus.crd      <= 1'b0;
      bus.csel     <= '0;
      bus.caddr_wr <= '0;
      bus.caddr_rd <= '0;
      bus.cdata_wr <= '0;
      bus.err      <= 1'b0;
      rd_id        <= 1'b0;
    end else begin
      bus.cwr      <= 1'b0;
      bus.crd      <= 1'b0;
      bus.csel     <= '0;
      bus.caddr_wr <= '0;
      bus.caddr_rd <= '0;
      bus.cdata_wr <= '0;
      bus.err      <= (any_gnt && !win_legal) || timeout;
      if (any_gnt && win_legal) begin
        bus.csel <= win_sel;
        rd_id    <= win_id;
        if (win_we) begin
          bus.cwr      <= 1'b1;
          bus.caddr_wr <= win_addr;
          bus.cdata_wr <= win_wdata;
        end else begin
          bus.crd      <= 1'b1;
          bus.caddr_rd <= win_addr;
        end
      end
    end
  end

  // Read return: memory data sampled at the end of the read-strobe cycle, presented one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata     <= '0;
      bus.r0_rvalid <= 1'b0;
      bus.r1_rvalid <= 1'b0;
    end else begin
      bus.r0_rvalid <= bus.crd && !rd_id;
      bus.r1_rvalid <= bus.crd && rd_id;
      if (bus.crd) begin
        bus.rdata <= bus.cdata_rd;
      end
    end
  end

endmodule

// File: tb/tb_cmem_arb.sv
// Randomized self-checking bench for cmem_arb against a transaction-level model
// of the arbitration rules, plus a few directed scenarios.
module tb_cmem_arb;

  localparam int AW      = 12;
  localparam int DW      = 20;
  localparam int LOCK_TO = 16;

  logic clk;
  logic reset;

  cmem_arb_if #(.AW(AW), .DW(DW)) bus ();

  cmem_arb #(.AW(AW), .DW(DW), .LOCK_TO(LOCK_TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: owner -1 means nobody holds the lock.
  int m_rr    = 0;
  int m_owner = -1;
  int m_idle  = 0;

  // Expected memory-port / return values for the current cycle.
  logic          e_cwr, e_crd, e_err, e_rv0, e_rv1;
  logic [2:0]    e_csel;
  logic [AW-1:0] e_caddr_wr, e_caddr_rd;
  logic [DW-1:0] e_cdata_wr, e_rdata;
  int            e_rd_id;

  int   last_win;
  logic obs_g0, obs_g1;
  bit   force_mem = 1'b0;
  logic [DW-1:0] forced_mem = '0;
  int   idle_left [2];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n, input bit req, input bit we, input bit lock,
                               input logic [2:0] sel, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    if (n == 0) begin
      bus.r0_req = req; bus.r0_we = we; bus.r0_lock = lock;
      bus.r0_sel = sel; bus.r0_addr = addr; bus.r0_wdata = wdata;
    end else begin
      bus.r1_req = req; bus.r1_we = we; bus.r1_lock = lock;
      bus.r1_sel = sel; bus.r1_addr = addr; bus.r1_wdata = wdata;
    end
  endtask

  task automatic clear_expect();
    e_cwr = 0; e_crd = 0; e_err = 0; e_rv0 = 0; e_rv1 = 0; e_csel = '0;
    e_caddr_wr = '0; e_caddr_rd = '0; e_cdata_wr = '0; e_rdata = '0; e_rd_id = 0;
  endtask

  // One clock cycle: compare at the falling edge, then advance the model to the next cycle.
  task automatic step();
    bit r [2];
    int w;
    bit fire, legal, we, lk;
    logic [2:0] s;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic n_cwr, n_crd, n_err, n_rv0, n_rv1;
    logic [2:0] n_csel;
    logic [AW-1:0] n_caddr_wr, n_caddr_rd;
    logic [DW-1:0] n_cdata_wr, n_rdata;
    int n_rd_id;

    @(negedge clk);
    r[0] = bus.r0_req;
    r[1] = bus.r1_req;
    if (reset)                w = -1;
    else if (m_owner >= 0)    w = r[m_owner] ? m_owner : -1;
    else if (r[0] && r[1])    w = m_rr;
    else if (r[0])            w = 0;
    else if (r[1])            w = 1;
    else                      w = -1;

    obs_g0 = bus.r0_gnt;
    obs_g1 = bus.r1_gnt;
    checkOutput("r0_gnt", 32'(bus.r0_gnt), 32'(w == 0));
    checkOutput("r1_gnt", 32'(bus.r1_gnt), 32'(w == 1));
    checkOutput("cwr", 32'(bus.cwr), 32'(e_cwr));
    checkOutput("crd", 32'(bus.crd), 32'(e_crd));
    checkOutput("csel", 32'(bus.csel), 32'(e_csel));
    checkOutput("caddr_wr", 32'(bus.caddr_wr), 32'(e_caddr_wr));
    checkOutput("caddr_rd", 32'(bus.caddr_rd), 32'(e_caddr_rd));
    checkOutput("cdata_wr", 32'(bus.cdata_wr), 32'(e_cdata_wr));
    checkOutput("err", 32'(bus.err), 32'(e_err));
    checkOutput("r0_rvalid", 32'(bus.r0_rvalid), 32'(e_rv0));
    checkOutput("r1_rvalid", 32'(bus.r1_rvalid), 32'(e_rv1));
    checkOutput("rdata", 32'(bus.rdata), 32'(e_rdata));
    last_win = w;

    n_cwr = 0; n_crd = 0; n_err = 0; n_csel = '0;
    n_caddr_wr = '0; n_caddr_rd = '0; n_cdata_wr = '0; n_rd_id = e_rd_id;
    if (reset) begin
      m_rr = 0; m_owner = -1; m_idle = 0;
      n_rv0 = 0; n_rv1 = 0; n_rdata = '0;
    end else begin
      n_rv0   = e_crd && (e_rd_id == 0);
      n_rv1   = e_crd && (e_rd_id == 1);
      n_rdata = e_crd ? bus.cdata_rd : e_rdata;

      fire = 0;
      if (m_owner >= 0 && !r[m_owner]) begin
        m_idle++;
        if (m_idle == LOCK_TO) begin
          fire = 1;
          m_rr = 1 - m_owner;
          m_owner = -1;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end

      legal = 1;
      if (w >= 0) begin
        we = (w == 0) ? bus.r0_we   : bus.r1_we;
        lk = (w == 0) ? bus.r0_lock : bus.r1_lock;
        s  = (w == 0) ? bus.r0_sel  : bus.r1_sel;
        a  = (w == 0) ? bus.r0_addr : bus.r1_addr;
        d  = (w == 0) ? bus.r0_wdata : bus.r1_wdata;
        legal = (s >= 1) && (s <= 5);
        if (legal) begin
          n_csel = s;
          n_rd_id = w;
          if (we) begin n_cwr = 1; n_caddr_wr = a; n_cdata_wr = d; end
          else    begin n_crd = 1; n_caddr_rd = a; end
        end
        if (lk) m_owner = w;
        else begin
          if (m_owner == w) m_owner = -1;
          m_rr = 1 - w;
        end
      end
      n_err = ((w >= 0) && !legal) || fire;
    end

    @(posedge clk);
    #1;
    bus.cdata_rd = force_mem ? forced_mem : DW'($urandom);
    e_cwr = n_cwr; e_crd = n_crd; e_err = n_err; e_csel = n_csel;
    e_caddr_wr = n_caddr_wr; e_caddr_rd = n_caddr_rd; e_cdata_wr = n_cdata_wr;
    e_rv0 = n_rv0; e_rv1 = n_rv1; e_rdata = n_rdata; e_rd_id = n_rd_id;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic random_request(input int n);
    bit we, lk;
    logic [2:0] s;
    we = 1'($urandom % 2);
    lk = ($urandom % 4) == 0;
    if (($urandom % 8) == 0) s = ($urandom % 3 == 0) ? 3'd0 : 3'($urandom_range(6, 7));
    else                     s = 3'($urandom_range(1, 5));
    applyStimulus(n, 1, we, lk, s, AW'($urandom), DW'($urandom));
  endtask

  // Requester behaviour: idle gap after a grant, occasional abandonment of a waiting request.
  task automatic drive_requester(input int n);
    bit cur;
    cur = (n == 0) ? bus.r0_req : bus.r1_req;
    if (cur && last_win == n) begin
      idle_left[n] = ($urandom % 4 == 0) ? $urandom_range(0, 22) : $urandom_range(0, 2);
      applyStimulus(n, 0, 0, 0, 3'd0, '0, '0);
      if (idle_left[n] == 0) random_request(n);
    end else if (cur && ($urandom % 30) == 0) begin
      idle_left[n] = $urandom_range(0, 3);
      applyStimulus(n, 0, 0, 0, 3'd0, '0, '0);
    end else if (!cur) begin
      if (idle_left[n] == 0) random_request(n);
      else idle_left[n]--;
    end
  endtask

  initial begin
    int seq [4];
    int first_r1, err_seen;

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 3'd0, '0, '0);
    applyStimulus(1, 0, 0, 0, 3'd0, '0, '0);
    bus.cdata_rd = '0;
    clear_expect();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    $display("[TB] directed: single write");
    applyStimulus(0, 1, 1, 0, 3'd1, 12'h005, 20'h00ABC);
    step();
    checkOutput("wr_gnt", 32'(obs_g0), 32'd1);
    applyStimulus(0, 0, 0, 0, 3'd0, '0, '0);
    checkOutput("wr_cwr", 32'(bus.cwr), 32'd1);
    checkOutput("wr_addr", 32'(bus.caddr_wr), 32'h005);
    checkOutput("wr_data", 32'(bus.cdata_wr), 32'h00ABC);
    checkOutput("wr_csel", 32'(bus.csel), 32'd1);
    step();

    $display("[TB] directed: r1 read return");
    applyStimulus(1, 1, 0, 0, 3'd3, 12'h010, '0);
    force_mem = 1'b1;
    forced_mem = 20'h12345;
    step();
    applyStimulus(1, 0, 0, 0, 3'd0, '0, '0);
    checkOutput("rd_crd", 32'(bus.crd), 32'd1);
    checkOutput("rd_addr", 32'(bus.caddr_rd), 32'h010);
    checkOutput("rd_csel", 32'(bus.csel), 32'd3);
    force_mem = 1'b0;
    step();
    checkOutput("rd_r1_rvalid", 32'(bus.r1_rvalid), 32'd1);
    checkOutput("rd_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
    checkOutput("rd_rdata", 32'(bus.rdata), 32'h12345);
    step();

    $display("[TB] directed: alternating grants");
    do_reset();
    applyStimulus(0, 1, 1, 0, 3'd2, 12'h100, 20'h11111);
    applyStimulus(1, 1, 1, 0, 3'd4, 12'h200, 20'h22222);
    for (int i = 0; i < 4; i++) begin
      step();
      seq[i] = obs_g1 ? 1 : (obs_g0 ? 0 : -1);
      checkOutput("rr_busy", 32'(bus.cwr), 32'd1);
    end
    for (int i = 0; i < 4; i++) checkOutput("rr_order", 32'(seq[i]), 32'(i % 2));
    applyStimulus(0, 0, 0, 0, 3'd0, '0, '0);
    applyStimulus(1, 0, 0, 0, 3'd0, '0, '0);
    step();

    $display("[TB] directed: locked burst");
    do_reset();
    applyStimulus(1, 1, 1, 0, 3'd4, 12'h0AA, 20'h0BBBB);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) applyStimulus(0, 1, 0, 1, 3'd2, AW'(k), '0);
      else       applyStimulus(0, 1, 1, 0, 3'd2, 12'h0FF, 20'h0CCCC);
      step();
      checkOutput("lock_r0_gnt", 32'(obs_g0), 32'd1);
      checkOutput("lock_r1_wait", 32'(obs_g1), 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 3'd0, '0, '0);
    step();
    checkOutput("lock_r1_after", 32'(obs_g1), 32'd1);
    applyStimulus(1, 0, 0, 0, 3'd0, '0, '0);
    step();

    $display("[TB] directed: lock timeout and illegal select");
    do_reset();
    applyStimulus(0, 1, 1, 1, 3'd1, 12'h001, 20'h00001);
    step();
    applyStimulus(0, 0, 0, 0, 3'd0, '0, '0);
    applyStimulus(1, 1, 0, 0, 3'd2, 12'h002, '0);
    first_r1 = -1;
    err_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (obs_g1 && first_r1 < 0) begin
        first_r1 = i;
        applyStimulus(1, 0, 0, 0, 3'd0, '0, '0);
      end
      if (bus.err) err_seen++;
    end
    checkOutput("to_first_r1", 32'(first_r1), 32'(LOCK_TO + 1));
    checkOutput("to_err_count", 32'(err_seen), 32'd1);
    applyStimulus(0, 1, 1, 0, 3'd7, 12'h003, 20'h00003);
    step();
    checkOutput("sel7_gnt", 32'(obs_g0), 32'd1);
    applyStimulus(0, 0, 0, 0, 3'd0, '0, '0);
    checkOutput("sel7_cwr", 32'(bus.cwr), 32'd0);
    checkOutput("sel7_crd", 32'(bus.crd), 32'd0);
    checkOutput("sel7_err", 32'(bus.err), 32'd1);
    step();

    $display("[TB] random traffic");
    idle_left[0] = 0;
    idle_left[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) reset = 1'b1;
      step();
      reset = 1'b0;
      drive_requester(0);
      drive_requester(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmem_arb.md
CMEM_ARB -- requirements
Module: cmem_arb

Interface
REQ-001 SHALL have parameter AW, default 12, meaning layer-memory address width.
REQ-002 SHALL have parameter DW, default 20, meaning layer-memory data width.
REQ-003 SHALL have parameter LOCK_TO, default 16, meaning idle cycles before a held lock is forcibly released.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rN_req  input  1  (N=0,1) request valid; held with fields stable until rN_gnt.
REQ-007 rN_we  input  1  1=write, 0=read.
REQ-008 rN_lock  input  1  keep ownership after this transfer.
REQ-009 rN_sel  input  3  target layer memory (csel code, legal 1..5).
REQ-010 rN_addr  input  AW  memory address.
REQ-011 rN_wdata  input  DW  write data.
REQ-012 rN_gnt  output  1  request accepted this cycle.
REQ-013 rN_rvalid  output  1  read data valid for requester N.
REQ-014 rdata  output  DW  shared read-return data.
REQ-015 cwr, crd  output  1  memory write/read strobes.
REQ-016 caddr_wr, caddr_rd  output  AW  memory write/read addresses.
REQ-017 cdata_wr  output  DW  memory write data.
REQ-018 cdata_rd  input  DW  memory read data, valid in the same cycle as crd.
REQ-019 csel  output  3  memory select.
REQ-020 err  output  1  one-cycle error pulse.

Function
REQ-021 rN_gnt SHALL be combinational from current state and rN_req; at most one gnt high per cycle.
REQ-022 Only one requester: SHALL be granted when not blocked by the other's lock.
REQ-023 Both requesting, no lock owner: SHALL grant the requester indicated by round-robin pointer rr (0 = r0); after any unlocked grant rr SHALL point to the other requester.
REQ-024 Lock owner valid: only the owner SHALL be granted; other requester waits with no gnt.
REQ-025 Granted request with rN_lock=1 SHALL set owner=N; granted owner request with rN_lock=0 SHALL clear owner after that transfer.
REQ-026 Accepted command (cycle T) SHALL be registered and drive the memory port during cycle T+1 only; one command per cycle, back-to-back accepted.
REQ-027 Write in T+1: cwr=1, caddr_wr=addr, cdata_wr=wdata, csel=sel, crd=0.
REQ-028 Read in T+1: crd=1, caddr_rd=addr, csel=sel, cwr=0; cdata_rd captured at end of T+1.
REQ-029 Read return: rdata=captured data and rN_rvalid=1 for the issuing requester only, during cycle T+2 for exactly one cycle; rdata held otherwise.
REQ-030 Memory port idle cycles: cwr=0, crd=0, csel=0, caddr_wr/caddr_rd/cdata_wr=0.
REQ-031 Illegal sel (0, 6, 7): request SHALL still be granted, no cwr/crd issued, no rvalid, err=1 in T+1.
REQ-032 Lock timeout: owner with rN_req=0 for LOCK_TO consecutive cycles SHALL have ownership cleared on the next edge, err=1 for one cycle, rr pointed to the other requester; counter clears whenever owner requests or owner cleared.
REQ-033 Illegal sel and timeout in the same cycle SHALL produce a single err pulse.
REQ-034 Request deasserted before gnt SHALL be dropped with no memory activity.

Reset
REQ-035 reset=1 at a rising edge SHALL clear all outputs to 0, rr=0, owner=none, timeout counter=0.
REQ-036 Reset mid-operation SHALL discard registered command and pending read: no cwr/crd/rvalid in the cycles after reset.
REQ-037 While reset=1 all rN_gnt SHALL be 0.

Verification
REQ-038 r0 write sel=1 addr=0x005 data=0x00ABC -> r0_gnt T, T+1 cwr=1 caddr_wr=0x005 cdata_wr=0x00ABC csel=1.
REQ-039 Both request continuously after reset -> gnt order r0,r1,r0,r1; one memory op per cycle, no gaps.
REQ-040 r1 read sel=3 addr=0x010, memory returns 0x12345 -> T+1 crd=1 caddr_rd=0x010 csel=3; T+2 r1_rvalid=1 rdata=0x12345, r0_rvalid=0.
REQ-041 r0 four locked reads then unlocked write, r1 requesting throughout -> r1_gnt=0 until after r0's write gnt, then r1 granted next cycle.
REQ-042 r0 locks then idles 16 cycles, r1 requesting -> err pulse once, r1 granted cycle after release; sel=7 request -> gnt, no strobes, err pulse.
